muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the multicycle core. It executes MULT, MULTU, DIV and DIVU by time-sharing the existing 32-bit ALU: one ALU operation (ADDU or SUBU) per granted cycle, plus carry/compare logic held locally. It sits beside the main control FSM, which arbitrates the ALU through a req/gnt pair. Results land in dedicated HI/LO output registers.

## Interface
- No parameters; width fixed at 32, ALUOp width fixed at 6.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: start pulse; sampled only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched with `start`.
- `rs_val` in 32: multiplicand / dividend; latched with `start`.
- `rt_val` in 32: multiplier / divisor; latched with `start`.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse in DONE.
- `hi`, `lo` out 32: result registers.
- `alu_req` out 1: sequencer needs the ALU this cycle.
- `alu_gnt` in 1: ALU granted; an ALU step completes only when `alu_req && alu_gnt`.
- `alu_srca`, `alu_srcb` out 32; `alu_op` out 6: ALU operand/opcode drive.
- `alu_result` in 32: combinational ALU result, sampled on granted cycles.

## Operation
- States: IDLE, PRE, ITER, POST, DONE.
- IDLE: on `start`, latch operands and op. Divisor==0 for DIV/DIVU goes to DONE with hi=dividend, lo=0xFFFFFFFF, no ALU use. Otherwise go to PRE if a signed op has a negative operand, else ITER.
- PRE: one step per negative signed operand, computing the magnitude as SUBU 0−x. rs is negated first, then rt.
- ITER: exactly 32 granted steps, counted by a 5-bit counter plus a terminal flag.
  - Multiply, step: registers acc (hi) and mq (lo).
    - ALU ADDU: srca=acc; srcb=mcand if mq[0]=1, else 0.
    - carry = (alu_result < alu_srca).
    - {acc,mq} ← {carry, alu_result, mq[31:1]}.
  - Divide, step: restoring algorithm with rem and q.
    - r33 = {rem, q[31]}.
    - ALU SUBU: srca=r33[31:0], srcb=d.
    - If r33 ≥ {0,d} (local 33-bit compare): rem←alu_result, q←{q[30:0],1}.
    - Else: rem←r33[31:0], q←{q[30:0],0}.
- POST (signed ops only, fixups in this order):
  - MULT with operand signs differing, 2 steps:
    - lo ← 0−lo.
    - hi ← 0−hi if the pre-negation lo==0, else hi ← 0xFFFFFFFF−hi. Both use SUBU.
  - DIV:
    - Negate the quotient if operand signs differ.
    - Negate the remainder if the dividend was negative.
  - Steps that are not needed are skipped.
- The edge entering DONE loads `hi`/`lo`:
  - Multiply: hi=acc, lo=mq.
  - Divide: hi=rem, lo=q.
  - The registers hold until the next result. DONE then returns to IDLE unconditionally.
- DIV −2^31/−1 returns lo=0x80000000, hi=0; no trap.
- `start` while busy: ignored.
- Every ALU opcode comes from the shared ALUOp defines (ADDU, SUBU). In IDLE/DONE: srca=srcb=0, alu_op=ADDU, alu_req=0.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, alu_req=0, srca=srcb=0, alu_op=ADDU; state IDLE, counter 0.
- `rst_n` low mid-operation aborts immediately. No partial result reaches hi/lo.
- ALU drive (`alu_req`, `alu_srca`, `alu_srcb`, `alu_op`) is decoded from registered state only. It holds stable across ungranted cycles.
- State advances only on granted steps. `alu_gnt` low simply stalls.
- With `start` accepted in cycle N and `alu_gnt` tied high:
  - busy is high N+1 through done.
  - done = N+1+P+32+Q, where P = PRE steps (0–2) and Q = POST steps (0–2).
  - Divide-by-zero: done at N+1.
- hi/lo are valid in the done cycle.

## Structure
- Shared define/package holds:
  - the muldiv op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the state encodings;
  - the existing ALUOp defines (ADDU, SUBU), reused.
- Single module; no sub-module warranted. The step datapath is a small always block keyed by op class.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF, gnt=1 → done at N+33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD×5, gnt=1 → done at N+36; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV 0xFFFFFFF9/2, gnt=1 → done at N+36; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 with gnt toggling every cycle → hi=2, lo=14. Exactly 32 granted ITER steps; ALU drive stable on ungranted cycles.
- DIV 5/0 → done at N+1; hi=5, lo=0xFFFFFFFF; alu_req never asserted.
- rst_n low at ITER step 10 → all outputs at reset values asynchronously. A `start` issued while busy is ignored, and the previous hi/lo are unchanged.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multicycle core's multiply/divide sequencer:
// muldiv op codes, sequencer states and the ALUOp codes it reuses.
package muldiv_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int ALUOP_W = 6;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ITER = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    // Existing core ALUOp codes; only these two are issued by the sequencer.
    localparam logic [ALUOP_W-1:0] ALU_ADDU = 6'b100001;
    localparam logic [ALUOP_W-1:0] ALU_SUBU = 6'b100011;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that time-shares the core ALU,
// one granted ADDU/SUBU per step, and leaves results in hi/lo.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [5:0]  alu_op,
    input  logic [31:0] alu_result
);

    md_state_e   state, state_nxt;
    logic [1:0]  op_r;
    logic [4:0]  cnt;
    logic        pre_rs_pend, pre_rt_pend, post_lo_pend, post_hi_pend, lo_zero;
    logic [31:0] acc, mq, opb;
    logic [31:0] acc_nxt, mq_nxt, opb_nxt;

    // acc/mq double as rem/q; rs sits in opb for multiply and in mq for divide.
    logic        op_div, div_zero, rs_neg_in, rt_neg_in, step, ge, carry;
    logic [31:0] rs_cur, rt_cur;
    logic [32:0] r33;

    assign op_div    = md_is_div(op_r);
    assign div_zero  = md_is_div(op) && (rt_val == '0);
    assign rs_neg_in = md_is_signed(op) && rs_val[31];
    assign rt_neg_in = md_is_signed(op) && rt_val[31];
    assign rs_cur    = op_div ? mq : opb;
    assign rt_cur    = op_div ? opb : mq;
    assign r33       = {acc, mq[31]};
    assign ge        = r33 >= {1'b0, opb};
    assign carry     = alu_result < alu_srca;
    assign step      = alu_req && alu_gnt;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        alu_req   = 1'b0;
        alu_srca  = '0;
        alu_srcb  = '0;
        alu_op    = ALU_ADDU;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (div_zero)                    state_nxt = ST_DONE;
                    else if (rs_neg_in || rt_neg_in) state_nxt = ST_PRE;
                    else                             state_nxt = ST_ITER;
                end
            end
            ST_PRE: begin
                alu_req  = 1'b1;
                alu_op   = ALU_SUBU;
                alu_srcb = pre_rs_pend ? rs_cur : rt_cur;
                if (alu_gnt && !(pre_rs_pend && pre_rt_pend)) state_nxt = ST_ITER;
            end
            ST_ITER: begin
                alu_req = 1'b1;
                if (op_div) begin
                    alu_op   = ALU_SUBU;
                    alu_srca = r33[31:0];
                    alu_srcb = opb;
                end else begin
                    alu_srca = acc;
                    alu_srcb = mq[0] ? opb : '0;
                end
                if (alu_gnt && cnt == 5'd31)
                    state_nxt = (post_lo_pend || post_hi_pend) ? ST_POST : ST_DONE;
            end
            ST_POST: begin
                alu_req = 1'b1;
                alu_op  = ALU_SUBU;
                if (post_lo_pend) begin
                    alu_srcb = mq;
                end else begin
                    // Multiply high half borrows from the low half unless lo was zero.
                    alu_srca = (!op_div && !lo_zero) ? '1 : '0;
                    alu_srcb = acc;
                end
                if (alu_gnt && !(post_lo_pend && post_hi_pend)) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_nxt = acc;
        mq_nxt  = mq;
        opb_nxt = opb;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    acc_nxt = '0;
                    mq_nxt  = md_is_div(op) ? rs_val : rt_val;
                    opb_nxt = md_is_div(op) ? rt_val : rs_val;
                end
            end
            ST_PRE: begin
                if (step) begin
                    if (pre_rs_pend == op_div) mq_nxt  = alu_result;
                    else                       opb_nxt = alu_result;
                end
            end
            ST_ITER: begin
                if (step) begin
                    if (op_div) begin
                        acc_nxt = ge ? alu_result : r33[31:0];
                        mq_nxt  = {mq[30:0], ge};
                    end else begin
                        acc_nxt = {carry, alu_result[31:1]};
                        mq_nxt  = {alu_result[0], mq[31:1]};
                    end
                end
            end
            ST_POST: begin
                if (step) begin
                    if (post_lo_pend) mq_nxt  = alu_result;
                    else              acc_nxt = alu_result;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        acc <= acc_nxt;
        mq  <= mq_nxt;
        opb <= opb_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_r         <= MD_MULT;
            cnt          <= '0;
            pre_rs_pend  <= 1'b0;
            pre_rt_pend  <= 1'b0;
            post_lo_pend <= 1'b0;
            post_hi_pend <= 1'b0;
            lo_zero      <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                op_r         <= op;
                cnt          <= '0;
                pre_rs_pend  <= rs_neg_in;
                pre_rt_pend  <= rt_neg_in;
                post_lo_pend <= rs_neg_in ^ rt_neg_in;
                post_hi_pend <= md_is_div(op) ? rs_neg_in : (rs_neg_in ^ rt_neg_in);
                if (div_zero) begin
                    hi <= rs_val;
                    lo <= '1;
                end
            end
            if (step) begin
                case (state)
                    ST_PRE: begin
                        if (pre_rs_pend) pre_rs_pend <= 1'b0;
                        else             pre_rt_pend <= 1'b0;
                    end
                    ST_ITER: cnt <= cnt + 5'd1;
                    ST_POST: begin
                        if (post_lo_pend) begin
                            post_lo_pend <= 1'b0;
                            lo_zero      <= (mq == '0);
                        end else begin
                            post_hi_pend <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (state != ST_IDLE && state_nxt == ST_DONE) begin
                hi <= acc_nxt;
                lo <= mq_nxt;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural ALU and a reference
// model built on native SystemVerilog multiply/divide.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        busy, done, alu_req;
    logic        alu_gnt = 1'b0;
    logic [31:0] hi, lo, alu_srca, alu_srcb, alu_result;
    logic [5:0]  alu_op;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          steps;
    } exp_t;

    exp_t sb[$];

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .alu_req(alu_req), .alu_gnt(alu_gnt),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    assign alu_result = (alu_op == ALU_SUBU) ? alu_srca - alu_srcb : alu_srca + alu_srcb;

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa, sbv, sp;
        logic [63:0] up;
        int ia, ib, p, q;
        bit sg;
        sg = (o == MD_MULT) || (o == MD_DIV);
        p  = sg ? (int'(a[31]) + int'(b[31])) : 0;
        q  = 0;
        case (o)
            MD_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32]; e.lo = up[31:0];
            end
            MD_MULT: begin
                sa = $signed(a); sbv = $signed(b); sp = sa * sbv;
                e.hi = sp[63:32]; e.lo = sp[31:0];
                q = (a[31] ^ b[31]) ? 2 : 0;
            end
            MD_DIVU: begin
                e.hi = (b == 0) ? a : a % b;
                e.lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
            end
            default: begin
                ia = $signed(a); ib = $signed(b);
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'h0; e.lo = 32'h8000_0000;
                end else begin
                    e.lo = ia / ib; e.hi = ia % ib;
                end
                q = int'(a[31] ^ b[31]) + int'(a[31]);
            end
        endcase
        if ((o == MD_DIV || o == MD_DIVU) && b == 0) begin
            e.steps = 0; e.lat = 1;
        end else begin
            e.steps = p + 32 + q; e.lat = 1 + p + 32 + q;
        end
        return e;
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int gmode, input int inject);
        exp_t e;
        int k, steps, req_cycles;
        bit got, prev_stall;
        logic [31:0] sa_q, sb_q;
        logic [5:0]  op_q;
        @(negedge clk);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        alu_gnt = (gmode == 0);
        sb.push_back(model(o, a, b));
        k = 0; got = 0; steps = 0; req_cycles = 0; prev_stall = 0;
        sa_q = '0; sb_q = '0; op_q = '0;
        e = '{default: 0};
        while (!got && k < 400) begin
            @(negedge clk);
            k++;
            start = (k == inject);
            if (k == inject) begin
                op = MD_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'h1234_5678;
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b want 1", name, k, busy);
            end
            if (prev_stall) begin
                vectors++;
                if ({alu_req, alu_srca, alu_srcb, alu_op} !== {1'b1, sa_q, sb_q, op_q}) begin
                    miscompares++;
                    $display("FAIL %s stall drive cycle %0d: got %h/%h/%h want %h/%h/%h",
                             name, k, alu_srca, alu_srcb, alu_op, sa_q, sb_q, op_q);
                end
            end
            if (done === 1'b1) begin
                got = 1;
                e = sb.pop_front();
                vectors++;
                if (hi !== e.hi) begin
                    miscompares++;
                    $display("FAIL %s hi: got %h want %h", name, hi, e.hi);
                end
                vectors++;
                if (lo !== e.lo) begin
                    miscompares++;
                    $display("FAIL %s lo: got %h want %h", name, lo, e.lo);
                end
                vectors++;
                if (steps !== e.steps) begin
                    miscompares++;
                    $display("FAIL %s granted steps: got %0d want %0d", name, steps, e.steps);
                end
                if (gmode == 0) begin
                    vectors++;
                    if (k !== e.lat) begin
                        miscompares++;
                        $display("FAIL %s done latency: got N+%0d want N+%0d", name, k, e.lat);
                    end
                end
                if (e.steps == 0) begin
                    vectors++;
                    if (req_cycles !== 0) begin
                        miscompares++;
                        $display("FAIL %s alu_req cycles: got %0d want 0", name, req_cycles);
                    end
                end
            end else begin
                if (alu_req) req_cycles++;
                case (gmode)
                    0:       alu_gnt = 1'b1;
                    1:       alu_gnt = ~alu_gnt;
                    default: alu_gnt = 1'($urandom_range(0, 1));
                endcase
                if (alu_req && alu_gnt) steps++;
                prev_stall = alu_req && !alu_gnt;
                sa_q = alu_srca; sb_q = alu_srcb; op_q = alu_op;
            end
        end
        start = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: got no done want done within 400 cycles", name);
            void'(sb.pop_front());
        end else begin
            @(negedge clk);
            vectors++;
            if ({busy, done, hi, lo} !== {2'b00, e.hi, e.lo}) begin
                miscompares++;
                $display("FAIL %s after done: got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h",
                         name, busy, done, hi, lo, e.hi, e.lo);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if ({busy, done, hi, lo, alu_req, alu_srca, alu_srcb, alu_op} !==
            {2'b00, 64'h0, 1'b0, 64'h0, ALU_ADDU}) begin
            miscompares++;
            $display("FAIL %s: got busy=%b done=%b hi=%h lo=%h req=%b a=%h b=%h op=%h want reset values",
                     name, busy, done, hi, lo, alu_req, alu_srca, alu_srcb, alu_op);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
        vectors++;
        if (hi !== 32'h0) begin miscompares++; $display("FAIL reset hi: got %h want 0", hi); end
        vectors++;
        if (lo !== 32'h0) begin miscompares++; $display("FAIL reset lo: got %h want 0", lo); end
        vectors++;
        if (alu_req !== 1'b0) begin miscompares++; $display("FAIL reset alu_req: got %b want 0", alu_req); end
        vectors++;
        if (alu_op !== ALU_ADDU) begin miscompares++; $display("FAIL reset alu_op: got %h want %h", alu_op, ALU_ADDU); end
        vectors++;
        if ({alu_srca, alu_srcb} !== 64'h0) begin
            miscompares++; $display("FAIL reset srcs: got %h %h want 0 0", alu_srca, alu_srcb);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multu;  run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0); endtask
    task automatic test_mult;   run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd5, 0, 0);          endtask
    task automatic test_div;    run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0);          endtask
    task automatic test_divu_toggle; run_op("divu_toggle", MD_DIVU, 32'd100, 32'd7, 1, 0);         endtask
    task automatic test_divzero;     run_op("div_zero",    MD_DIV,  32'd5, 32'd0, 0, 0);           endtask

    task automatic test_boundaries;
        run_op("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("mult_lozero", MD_MULT,  32'h8000_0000, 32'd2, 0, 0);
        run_op("mult_zero",   MD_MULT,  32'hFFFF_FFFD, 32'd0, 0, 0);
        run_op("mult_bothneg",MD_MULT,  32'hFFFF_FFF0, 32'h8000_0001, 0, 0);
        run_op("divu_small",  MD_DIVU,  32'd7, 32'd100, 0, 0);
        run_op("div_negdiv",  MD_DIV,   32'd7, 32'hFFFF_FFFE, 0, 0);
        run_op("divu_zero",   MD_DIVU,  32'hDEAD_BEEF, 32'd0, 0, 0);
    endtask

    task automatic test_abort;
        @(negedge clk);
        op = MD_MULTU; rs_val = 32'h1234_5678; rt_val = 32'h9ABC_DEF0; start = 1'b1; alu_gnt = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL abort pre busy: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort after release");
        run_op("post_abort", MD_DIVU, 32'd1000, 32'd33, 0, 0);
    endtask

    task automatic test_busy_start;
        run_op("busy_start", MD_DIVU, 32'd100, 32'd7, 0, 5);
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin
            miscompares++;
            $display("FAIL busy_start hold: got busy=%b hi=%h lo=%h want 0 2 e", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 1) == 1) a = -a;
            run_op("b2b_rand", o, a, b, 2, 0);
        end
    endtask

    initial begin
        test_reset;
        test_multu;
        test_mult;
        test_div;
        test_divu_toggle;
        test_divzero;
        test_boundaries;
        test_abort;
        test_busy_start;
        test_back_to_back;
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
